// File: rtl/tlm_pkg.sv
// Shared types, lamp codes and phase helpers for traffic_light_monitor.
package tlm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        RED    = 3'd3,
        FAULT  = 3'd4
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    // Legal successor in the GREEN -> YELLOW -> RED -> GREEN loop.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            RED:     return GREEN;
            default: return IDLE;
        endcase
    endfunction

    // Non-legal codes (including 000) map to IDLE, meaning "no lamp phase".
    function automatic phase_t code_phase(input logic [2:0] code);
        case (code)
            LAMP_GREEN:  return GREEN;
            LAMP_YELLOW: return YELLOW;
            LAMP_RED:    return RED;
            default:     return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tlm_if.sv
// Lamp bus plus monitor status/diagnostic outputs; master drives the lamps.
interface tlm_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       light;
    logic             clear_err;
    logic [2:0]       phase;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] round_cnt;
    logic             code_err;
    logic             seq_err;
    logic             timeout_err;
    logic             fault;

    modport master (
        output light, clear_err,
        input  phase, dwell_cnt, round_cnt, code_err, seq_err, timeout_err, fault
    );

    modport slave (
        input  light, clear_err,
        output phase, dwell_cnt, round_cnt, code_err, seq_err, timeout_err, fault
    );
endinterface

// File: rtl/tlm_sat_counter.sv
// W-bit counter with load-to-1, clear and saturating increment.
module tlm_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load1,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= W'(1);
        end else if (inc && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Checks lamp order and dwell on a registered copy of the one-hot light bus.
// Define TLM_DWELL_CHECK_EN to fault when a phase dwells beyond MAX_DWELL.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int MAX_DWELL = 4,
    parameter int CNT_W     = 8
) (
    input logic  clk,
    input logic  rst_n,
    tlm_if.slave bus
);

`ifdef TLM_DWELL_CHECK_EN
    localparam bit DWELL_CHECK = 1'b1;
`else
    localparam bit DWELL_CHECK = 1'b0;
`endif
    localparam logic [CNT_W-1:0] DWELL_LIMIT = CNT_W'(MAX_DWELL);

    logic [2:0]       light_q;
    phase_t           phase_q, phase_d;
    phase_t           code_ph;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;
    logic             tmo_q, tmo_d;
    logic             dwell_load, dwell_clr, dwell_inc;
    logic             round_inc;
    logic [CNT_W-1:0] round_q;
    logic [CNT_W-1:0] dwell_cnt;

    assign code_ph = code_phase(light_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_q    <= '0;
            phase_q    <= IDLE;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
            round_q    <= '0;
        end else begin
            light_q    <= bus.light;
            phase_q    <= phase_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
            tmo_q      <= tmo_d;
            if (round_inc) begin
                round_q <= round_q + 1'b1;
            end
        end
    end

    // Each branch raises at most one error, which gives code > seq > timeout.
    always_comb begin
        phase_d    = phase_q;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        tmo_d      = 1'b0;
        dwell_load = 1'b0;
        dwell_clr  = 1'b0;
        dwell_inc  = 1'b0;
        round_inc  = 1'b0;
        unique case (phase_q)
            IDLE: begin
                if (light_q != 3'b000) begin
                    if (code_ph != IDLE) begin
                        phase_d    = code_ph;
                        dwell_load = 1'b1;
                    end else begin
                        code_err_d = 1'b1;
                        phase_d    = FAULT;
                    end
                end
            end
            GREEN, YELLOW, RED: begin
                if (code_ph == IDLE) begin
                    code_err_d = 1'b1;
                    phase_d    = FAULT;
                end else if (code_ph == phase_q) begin
                    dwell_inc = 1'b1;
                    if (DWELL_CHECK && dwell_cnt == DWELL_LIMIT) begin
                        tmo_d   = 1'b1;
                        phase_d = FAULT;
                    end
                end else if (code_ph == next_phase(phase_q)) begin
                    phase_d    = code_ph;
                    dwell_load = 1'b1;
                    round_inc  = (phase_q == RED);
                end else begin
                    seq_err_d = 1'b1;
                    phase_d   = FAULT;
                end
            end
            FAULT: begin
                if (bus.clear_err) begin
                    phase_d   = IDLE;
                    dwell_clr = 1'b1;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    tlm_sat_counter #(.W(CNT_W)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .load1 (dwell_load),
        .clr   (dwell_clr),
        .inc   (dwell_inc),
        .cnt   (dwell_cnt)
    );

    assign bus.phase       = phase_q;
    assign bus.dwell_cnt   = dwell_cnt;
    assign bus.round_cnt   = round_q;
    assign bus.code_err    = code_err_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.timeout_err = tmo_q;
    assign bus.fault       = (phase_q == FAULT);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized and directed bench for traffic_light_monitor against a behavioural model.
module tb_traffic_light_monitor;

    localparam int MAXD = 4;
    localparam int CW   = 8;
    localparam int SAT  = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    tlm_if #(.CNT_W(CW)) bus ();

    traffic_light_monitor #(.MAX_DWELL(MAXD), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase numbers 0..4, counters as plain ints.
    int         m_phase = 0;
    int         m_dwell = 0;
    int         m_round = 0;
    bit         m_code  = 0;
    bit         m_seq   = 0;
    bit         m_tmo   = 0;
    logic [2:0] m_lq    = 3'b000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lamp_phase(input logic [2:0] c);
        case (c)
            3'b010:  return 1;
            3'b001:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (c)
            3'b010:  return 3'b001;
            3'b001:  return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dwell = 0; m_round = 0;
        m_code = 0; m_seq = 0; m_tmo = 0; m_lq = 3'b000;
    endtask

    // One rising edge: act on the previously registered code, then capture the new one.
    task automatic model_edge(input logic [2:0] l, input logic clr);
        int cp;
        bit to;
        cp = lamp_phase(m_lq);
        to = 0;
        m_code = 0; m_seq = 0; m_tmo = 0;
        if (m_phase == 0) begin
            if (m_lq != 3'b000) begin
                if (cp != 0) begin
                    m_phase = cp; m_dwell = 1;
                end else begin
                    m_code = 1; m_phase = 4;
                end
            end
        end else if (m_phase == 4) begin
            if (clr) begin
                m_phase = 0; m_dwell = 0;
            end
        end else if (cp == 0) begin
            m_code = 1; m_phase = 4;
        end else if (cp == m_phase) begin
`ifdef TLM_DWELL_CHECK_EN
            to = (m_dwell == MAXD);
`endif
            if (to) begin
                m_tmo = 1; m_phase = 4;
            end
            m_dwell = (m_dwell < SAT) ? m_dwell + 1 : SAT;
        end else if (cp == (m_phase % 3) + 1) begin
            if (m_phase == 3) m_round = (m_round + 1) % (SAT + 1);
            m_phase = cp; m_dwell = 1;
        end else begin
            m_seq = 1; m_phase = 4;
        end
        m_lq = l;
    endtask

    task automatic check_all();
        check_eq("phase",       32'(bus.phase),       32'(m_phase));
        check_eq("dwell_cnt",   32'(bus.dwell_cnt),   32'(m_dwell));
        check_eq("round_cnt",   32'(bus.round_cnt),   32'(m_round));
        check_eq("code_err",    32'(bus.code_err),    32'(m_code));
        check_eq("seq_err",     32'(bus.seq_err),     32'(m_seq));
        check_eq("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
        check_eq("fault",       32'(bus.fault),       32'(m_phase == 4));
    endtask

    task automatic step(input logic [2:0] l, input logic clr);
        @(negedge clk);
        bus.light     = l;
        bus.clear_err = clr;
        @(posedge clk);
        model_edge(l, clr);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted away from any edge; outputs must drop at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        bus.light     = 3'b000;
        bus.clear_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [2:0] cur;
    logic [2:0] nl;
    logic       c;
    int         r;

    initial begin
        rst_n         = 1'b0;
        bus.light     = 3'b000;
        bus.clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Normal round, then an illegal code while in GREEN.
        step(3'b010, 0); step(3'b001, 0); step(3'b100, 0); step(3'b010, 0);
        step(3'b110, 0);
        check_eq("round_after_round", 32'(bus.round_cnt), 32'd1);
        check_eq("green_dwell", 32'(bus.dwell_cnt), 32'd1);
        step(3'b110, 0);
        check_eq("illegal_code_err", 32'(bus.code_err), 32'd1);
        check_eq("illegal_phase", 32'(bus.phase), 32'd4);
        step(3'b000, 0);
        check_eq("code_err_width", 32'(bus.code_err), 32'd0);
        step(3'b000, 1);
        check_eq("clear_phase", 32'(bus.phase), 32'd0);
        check_eq("clear_dwell", 32'(bus.dwell_cnt), 32'd0);

        // Out-of-order GREEN -> RED.
        step(3'b010, 0); step(3'b100, 0); step(3'b100, 0);
        check_eq("ooo_seq_err", 32'(bus.seq_err), 32'd1);
        check_eq("ooo_phase", 32'(bus.phase), 32'd4);
        check_eq("ooo_round", 32'(bus.round_cnt), 32'd1);
        step(3'b000, 1);

        // Long hold of YELLOW.
        do_reset();
`ifdef TLM_DWELL_CHECK_EN
        repeat (6) step(3'b001, 0);
        check_eq("dwell_timeout", 32'(bus.timeout_err), 32'd1);
        check_eq("dwell_at_tmo", 32'(bus.dwell_cnt), 32'(MAXD + 1));
        check_eq("dwell_fault", 32'(bus.fault), 32'd1);
`else
        repeat (301) step(3'b001, 0);
        check_eq("dwell_sat", 32'(bus.dwell_cnt), 32'(SAT));
        check_eq("dwell_no_fault", 32'(bus.fault), 32'd0);
`endif

        // 256 legal rounds wrap round_cnt back to 0.
        do_reset();
        step(3'b010, 0);
        for (int i = 0; i < 256; i++) begin
            step(3'b001, 0); step(3'b100, 0); step(3'b010, 0);
        end
        step(3'b010, 0);
        check_eq("round_wrap", 32'(bus.round_cnt), 32'd0);
        check_eq("wrap_phase", 32'(bus.phase), 32'd1);

        // Reset mid-YELLOW, then 000 in IDLE must stay quiet.
        step(3'b001, 0); step(3'b001, 0);
        check_eq("pre_reset_yellow", 32'(bus.phase), 32'd2);
        do_reset();
        check_eq("post_reset_phase", 32'(bus.phase), 32'd0);
        repeat (4) step(3'b000, 0);

        // Randomized traffic, mostly legal with occasional faults, clears and resets.
        cur = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      nl = next_code(cur);
            else if (r < 78) nl = cur;
            else if (r < 88) nl = 3'($urandom_range(0, 7));
            else if (r < 95) nl = next_code(next_code(cur));
            else             nl = 3'b000;
            c = (m_phase == 4) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                nl = 3'b000;
            end
            step(nl, c);
            cur = nl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
